// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size encodings and default depth.
package mem_pkg;

  localparam int MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the MEM-stage pipeline and the data memory.
// Handshake: there is no backpressure. A request is taken on every posedge where
// memRead or memWrite is 1; the outcome shows one cycle later as a single-cycle
// pulse on readValid (load data in readData) or accessError (request rejected).
interface data_memory_if;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  accessSize;
  logic        loadUnsigned;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        readValid;
  logic        accessError;

  modport master (
    output memRead, memWrite, accessSize, loadUnsigned, address, writeData,
    input  readData, readValid, accessError
  );

  modport slave (
    input  memRead, memWrite, accessSize, loadUnsigned, address, writeData,
    output readData, readValid, accessError
  );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word from a memory word and sign- or zero-extends it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        zero_ext,
  output logic [31:0] value
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    value   = word;
    case (size)
      SIZE_BYTE: value = zero_ext ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: value = zero_ext ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default:   value = word;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed, reset-cleared data memory: one load or store per cycle, sub-word
// store merge, registered load result, and a rejection pulse for illegal requests.
module data_memory
  import mem_pkg::*;
#(
  parameter  int DEPTH = MEM_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  data_memory_if.slave  bus
);

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  size_e         size;
  logic          reject;
  logic          do_load;
  logic          do_store;
  logic          req_error;
  logic [3:0]    byte_en;
  logic [31:0]   write_lanes;
  logic [31:0]   merged;
  logic [31:0]   load_value;

  always_comb begin
    idx  = bus.address[AW+1:2];
    lane = bus.address[1:0];
    size = size_e'(bus.accessSize);

    // Checks are ordered by priority; only the first matching reason matters.
    reject = 1'b0;
    if (bus.memRead && bus.memWrite)              reject = 1'b1;
    else if (size == SIZE_RSVD)                   reject = 1'b1;
    else if (size == SIZE_HALF && bus.address[0]) reject = 1'b1;
    else if (size == SIZE_WORD && lane != 2'b00)  reject = 1'b1;
    else if (|bus.address[31:AW+2])               reject = 1'b1;

    do_load   = bus.memRead  && !reject;
    do_store  = bus.memWrite && !reject;
    req_error = (bus.memRead || bus.memWrite) && reject;

    byte_en     = 4'b0000;
    write_lanes = bus.writeData;
    case (size)
      SIZE_BYTE: begin
        byte_en     = 4'b0001 << lane;
        write_lanes = {4{bus.writeData[7:0]}};
      end
      SIZE_HALF: begin
        byte_en     = 4'b0011 << lane;
        write_lanes = {2{bus.writeData[15:0]}};
      end
      SIZE_WORD: byte_en = 4'b1111;
      default:   byte_en = 4'b0000;
    endcase

    // Replicated write data lets each lane pick its byte without a shifter.
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = byte_en[i] ? write_lanes[8*i +: 8] : mem[idx][8*i +: 8];
    end
  end

  load_extend u_load_extend (
    .word     (mem[idx]),
    .lane     (lane),
    .size     (size),
    .zero_ext (bus.loadUnsigned),
    .value    (load_value)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.readData    <= '0;
      bus.readValid   <= 1'b0;
      bus.accessError <= 1'b0;
    end else begin
      bus.readValid   <= do_load;
      bus.accessError <= req_error;
      if (do_load)  bus.readData <= load_value;
      if (do_store) mem[idx]     <= merged;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboarded bench for data_memory: a byte-array reference model predicts every
// cycle's {readValid, accessError, readData}; a monitor compares them off the clock edge.
module tb_data_memory;
  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  logic clk;
  logic reset;

  data_memory_if bus ();

  data_memory #(.DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic [7:0]  model_mem [NBYTES];
  logic [31:0] model_rd;
  logic [33:0] exp_q [$];   // {readValid, accessError, readData} per cycle
  int checks   = 0;
  int failures = 0;

  function automatic logic is_bad(input logic rd, input logic wr, input logic [1:0] sz,
                                  input logic [31:0] addr);
    if (rd && wr) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (addr % 4) != 0) return 1'b1;
    if (addr >= NBYTES) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    int n;
    logic [31:0] v;
    @(negedge clk);
    reset            = 1'b1;
    bus.memRead      = rd;
    bus.memWrite     = wr;
    bus.accessSize   = sz;
    bus.loadUnsigned = uns;
    bus.address      = addr;
    bus.writeData    = wd;
    if (!rd && !wr) begin
      exp_q.push_back({1'b0, 1'b0, model_rd});
    end else if (is_bad(rd, wr, sz, addr)) begin
      exp_q.push_back({1'b0, 1'b1, model_rd});
    end else begin
      n = 1 << sz;
      if (wr) begin
        for (int k = 0; k < n; k++) model_mem[int'(addr) + k] = wd[8*k +: 8];
        exp_q.push_back({1'b0, 1'b0, model_rd});
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(model_mem[int'(addr) + k]) << (8 * k));
        if (!uns && n == 1 && v[7])  v = v - 32'd256;
        if (!uns && n == 2 && v[15]) v = v - 32'd65536;
        model_rd = v;
        exp_q.push_back({1'b1, 1'b0, v});
      end
    end
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    req(1'b0, 1'b1, sz, 1'b0, addr, wd);
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
    req(1'b1, 1'b0, sz, uns, addr, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 2'd0, 1'b0, $urandom, $urandom);
  endtask

  // Reset cycle with a load request present; the request must be discarded.
  task automatic reset_cycle(input logic [31:0] addr);
    @(negedge clk);
    reset            = 1'b0;
    bus.memRead      = 1'b1;
    bus.memWrite     = 1'b0;
    bus.accessSize   = 2'd2;
    bus.loadUnsigned = 1'b0;
    bus.address      = addr;
    bus.writeData    = $urandom;
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
    model_rd = 32'h0;
    exp_q.push_back({1'b0, 1'b0, 32'h0});
  endtask

  // ---------------- monitor ----------------
  int rsp_n = 0;
  initial begin
    logic [33:0] exp_v;
    logic [33:0] got_v;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.readValid === 1'b1 && bus.accessError === 1'b1) begin
        failures++;
        $display("FAIL exclusive rsp#%0d readValid=%b accessError=%b required not both 1",
                 rsp_n, bus.readValid, bus.accessError);
      end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {bus.readValid, bus.accessError, bus.readData};
        checks++;
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL rsp#%0d got valid=%b err=%b data=%h required valid=%b err=%b data=%h",
                   rsp_n, got_v[33], got_v[32], got_v[31:0], exp_v[33], exp_v[32], exp_v[31:0]);
        end
        rsp_n++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [31:0] addr;
    logic [1:0]  sz;
    reset            = 1'b0;
    bus.memRead      = 1'b0;
    bus.memWrite     = 1'b0;
    bus.accessSize   = 2'd0;
    bus.loadUnsigned = 1'b0;
    bus.address      = 32'h0;
    bus.writeData    = 32'h0;
    model_rd         = 32'h0;

    reset_cycle(32'h0);
    reset_cycle(32'h4);

    // Word store/load and sub-word merge
    store(2'd2, 32'h10, 32'hDEADBEEF);
    load(2'd2, 1'b0, 32'h10);
    idle(1);
    store(2'd0, 32'h13, 32'h00000080);
    load(2'd0, 1'b0, 32'h13);
    load(2'd0, 1'b1, 32'h13);
    load(2'd2, 1'b0, 32'h10);

    // Half store, then misaligned half load
    store(2'd1, 32'h22, 32'h00001234);
    load(2'd1, 1'b0, 32'h22);
    load(2'd1, 1'b0, 32'h21);
    idle(1);

    // Out of range, reserved size, read+write conflict; contents must survive
    store(2'd2, 32'h8, 32'h11223344);
    load(2'd2, 1'b0, NBYTES);
    load(2'd3, 1'b0, 32'h8);
    req(1'b1, 1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFEF00D);
    store(2'd2, NBYTES + 8, 32'h55555555);
    load(2'd2, 1'b0, 32'h8);
    load(2'd2, 1'b0, 32'h10);
    load(2'd2, 1'b0, 32'h20);

    // Back-to-back loads
    store(2'd2, 32'h0, 32'd1);
    store(2'd2, 32'h4, 32'd2);
    store(2'd2, 32'h8, 32'd3);
    load(2'd2, 1'b0, 32'h0);
    load(2'd2, 1'b0, 32'h4);
    load(2'd2, 1'b0, 32'h8);

    // Reset in the middle of a load stream
    store(2'd2, 32'h4, 32'hA5A5A5A5);
    load(2'd2, 1'b0, 32'h4);
    reset_cycle(32'h4);
    load(2'd2, 1'b0, 32'h4);
    idle(1);

    // Randomized traffic, concentrated on the low words to force aliasing
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      addr = $urandom_range(0, 63);
      if ($urandom_range(0, 4) != 0 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 32'd1);
      r = $urandom_range(0, 19);
      if (r == 0) addr = addr + NBYTES * $urandom_range(1, 8);
      else if (r == 1) addr = addr | 32'h8000_0000;
      else if (r < 4) addr = $urandom_range(0, NBYTES - 1);
      r = $urandom_range(0, 19);
      if (r == 0)      req(1'b1, 1'b1, sz, $urandom_range(0, 1), addr, $urandom);
      else if (r < 3)  idle(1);
      else if (r < 11) load(sz, $urandom_range(0, 1), addr);
      else if (r < 19) store(sz, addr, $urandom);
      else             reset_cycle(addr);
    end

    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
